result_drain_bram: RTL and testbench



---
 rtl/result_drain_bram.sv | 139 +++++++++++++
 tb/tb_result_drain_bram.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/result_drain_bram.sv
// Drains packed result words from the result BRAM onto a valid/ready stream.
// Define DRAIN_LAST_EN to add an o_last flag on the final word of a run.
module result_drain_bram #(
    parameter int CNT_BIT  = 31,
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 12,
    parameter int MEM_SIZE = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_run,
    input  logic [CNT_BIT-1:0] i_num_cnt,
    output logic               o_idle,
    output logic               o_read,
    output logic               o_done,
    output logic [AWIDTH-1:0]  addr_b1,
    output logic               ce_b1,
    output logic               we_b1,
    input  logic [DWIDTH-1:0]  q_b1,
    output logic [DWIDTH-1:0]  d_b1,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DWIDTH-1:0]  o_data
`ifdef DRAIN_LAST_EN
    ,
    output logic               o_last
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CNT_BIT-1:0] MEM_SIZE_C = CNT_BIT'(MEM_SIZE);

    state_t             state_reg, state_next;
    logic [CNT_BIT-1:0] num_reg;
    logic [CNT_BIT-1:0] rd_cnt_reg;
    logic [CNT_BIT-1:0] tx_cnt_reg;
    logic [CNT_BIT-1:0] tx_cnt_inc;
    logic               inflight_reg;
    logic [DWIDTH-1:0]  buf_mem [2];
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic [1:0]         buf_count_reg;
    logic [2:0]         occupancy;
    logic               push;
    logic               pop;
    logic               last_pop;
    logic               start;

    assign push       = inflight_reg;
    assign pop        = o_valid & i_ready;
    assign tx_cnt_inc = tx_cnt_reg + CNT_BIT'(1);
    assign last_pop   = pop && (tx_cnt_inc == num_reg);
    assign start      = (state_reg == S_IDLE) && i_run;

    // Words already buffered plus the one returning from BRAM, less the one leaving now.
    assign occupancy = {1'b0, buf_count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign ce_b1     = (state_reg == S_RUN) && (rd_cnt_reg < num_reg) && (occupancy < 3'd2);
    assign addr_b1   = AWIDTH'(rd_cnt_reg % MEM_SIZE_C);
    assign we_b1     = 1'b0;
    assign d_b1      = '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (i_run) state_next = S_RUN;
            S_RUN:   if ((num_reg == '0) || last_pop) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_idle  = 1'b0;
        o_read  = 1'b0;
        o_done  = 1'b0;
        o_valid = 1'b0;
        case (state_reg)
            S_IDLE:  o_idle = 1'b1;
            S_RUN: begin
                o_read  = 1'b1;
                o_valid = (buf_count_reg != 2'd0);
            end
            S_DONE:  o_done = 1'b1;
            default: o_idle = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            num_reg       <= '0;
            rd_cnt_reg    <= '0;
            tx_cnt_reg    <= '0;
            inflight_reg  <= 1'b0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            buf_count_reg <= 2'd0;
        end else begin
            inflight_reg <= ce_b1;
            if (start) begin
                num_reg    <= i_num_cnt;
                rd_cnt_reg <= '0;
                tx_cnt_reg <= '0;
            end else begin
                if (ce_b1) rd_cnt_reg <= rd_cnt_reg + CNT_BIT'(1);
                if (pop)   tx_cnt_reg <= tx_cnt_inc;
            end
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            buf_count_reg <= buf_count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    // Data returning from BRAM lands in the slot the write pointer names.
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                buf_mem[gi] <= '0;
            end else if (push && (wr_ptr_reg == gi[0])) begin
                buf_mem[gi] <= q_b1;
            end
        end
    end

    assign o_data = o_valid ? buf_mem[rd_ptr_reg] : '0;

`ifdef DRAIN_LAST_EN
    assign o_last = o_valid && (tx_cnt_inc == num_reg);
`endif

endmodule

// File: tb/tb_result_drain_bram.sv
// Directed bench for result_drain_bram with a behavioural BRAM preloaded with {i, ~i}.
// Covers free-flow drain, backpressure, zero count, ignored start and mid-run reset.
module tb_result_drain_bram;

    localparam int CNT_BIT = 31;
    localparam int DWIDTH  = 32;
    localparam int AWIDTH  = 12;
    localparam int DEPTH   = 4096;

    logic               clk;
    logic               reset_n;
    logic               i_run;
    logic [CNT_BIT-1:0] i_num_cnt;
    logic               o_idle;
    logic               o_read;
    logic               o_done;
    logic [AWIDTH-1:0]  addr_b1;
    logic               ce_b1;
    logic               we_b1;
    logic [DWIDTH-1:0]  q_b1;
    logic [DWIDTH-1:0]  d_b1;
    logic               o_valid;
    logic               i_ready;
    logic [DWIDTH-1:0]  o_data;
`ifdef DRAIN_LAST_EN
    logic               o_last;
`endif

    logic [DWIDTH-1:0] bram [DEPTH];
    int errors = 0;
    int checks = 0;

    result_drain_bram #(
        .CNT_BIT(CNT_BIT), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MEM_SIZE(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .o_idle(o_idle), .o_read(o_read), .o_done(o_done),
        .addr_b1(addr_b1), .ce_b1(ce_b1), .we_b1(we_b1), .q_b1(q_b1), .d_b1(d_b1),
        .o_valid(o_valid), .i_ready(i_ready),
`ifdef DRAIN_LAST_EN
        .o_last(o_last),
`endif
        .o_data(o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ce_b1) q_b1 <= bram[addr_b1];
    end

    function automatic logic [31:0] word(input int i);
        logic [15:0] lo;
        lo = i[15:0];
        return {lo, ~lo};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a run at the current negedge and follows it to o_done, checking every beat.
    task automatic drain(input string tag, input int num, input logic [15:0] pat,
                         input bit stall_last, input bit poke_run, input int exp_done);
        int idx, issued, popped, done_cyc, first_valid;
        bit hold, stalled, pop;
        logic [31:0] held;
        idx = 0; issued = 0; popped = 0; done_cyc = -1; first_valid = -1;
        hold = 0; stalled = 0; held = '0;
        i_num_cnt = CNT_BIT'(num);
        i_run     = 1'b1;
        i_ready   = pat[0];
        @(negedge clk);
        i_run = 1'b0;
        for (int cyc = 0; cyc < 5000 && done_cyc < 0; cyc++) begin
            i_ready = pat[cyc % 16];
            if (stall_last && !stalled && o_valid && idx == num - 1) begin
                i_ready = 1'b0;
                stalled = 1;
            end
            i_run = poke_run && (cyc == 3);
            if (poke_run && cyc == 3) i_num_cnt = CNT_BIT'(2);
            #1;
            if (o_done) begin
                done_cyc = cyc;
                check($sformatf("%s_done_valid", tag), o_valid, 0);
            end else begin
                if (hold) check($sformatf("%s_hold%0d", tag, idx), {o_valid, o_data}, {1'b1, held});
                if (o_valid) begin
                    if (first_valid < 0) first_valid = cyc;
                    check($sformatf("%s_extra_beat", tag), idx < num, 1);
                    if (idx < num) check($sformatf("%s_data%0d", tag, idx), o_data, word(idx));
                end
`ifdef DRAIN_LAST_EN
                check($sformatf("%s_last_c%0d", tag, cyc), o_last, o_valid && (idx == num - 1));
`endif
                if (ce_b1) begin
                    check($sformatf("%s_addr%0d", tag, issued), addr_b1, issued % DEPTH);
                    issued++;
                end
                pop = o_valid && i_ready;
                if (pop) begin
                    idx++;
                    popped++;
                    hold = 0;
                end else begin
                    hold = o_valid;
                    held = o_data;
                end
                check($sformatf("%s_outstanding", tag), (issued - popped) <= 2, 1);
            end
            @(negedge clk);
        end
        check($sformatf("%s_done_seen", tag), done_cyc >= 0, 1);
        check($sformatf("%s_beats", tag), idx, num);
        check($sformatf("%s_reads", tag), issued, num);
        if (exp_done >= 0) check($sformatf("%s_done_cycle", tag), done_cyc, exp_done);
        if (num > 0) check($sformatf("%s_first_valid", tag), first_valid, 2);
        #1;
        check($sformatf("%s_idle_after", tag), {o_idle, o_done, o_valid}, 3'b100);
        @(negedge clk);
    endtask

    initial begin
        int pops;
        for (int i = 0; i < DEPTH; i++) bram[i] = word(i);
        reset_n   = 1'b0;
        i_run     = 1'b0;
        i_ready   = 1'b0;
        i_num_cnt = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_idle", o_idle, 1);
        check("rst_ctrl", {o_read, o_done, o_valid, ce_b1, we_b1}, 5'b0);
        check("rst_addr", addr_b1, 0);
        check("rst_data", o_data, 0);
        check("rst_d_b1", d_b1, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        drain("full", 4096, 16'hFFFF, 0, 0, 4098);
        drain("bp", 8, 16'b0110_1010_0010_1001, 0, 0, -1);
        drain("zero", 0, 16'hFFFF, 0, 0, 1);
        drain("poke", 6, 16'hFFFF, 0, 1, 8);

        // Reset after five beats of a long run; everything in flight must vanish.
        i_num_cnt = CNT_BIT'(100);
        i_run     = 1'b1;
        i_ready   = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        pops  = 0;
        for (int cyc = 0; cyc < 20 && pops < 5; cyc++) begin
            #1;
            if (o_valid && i_ready) pops++;
            @(negedge clk);
        end
        check("mid_pops", pops, 5);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_idle", o_idle, 1);
        check("mid_rst_ce", ce_b1, 0);
        reset_n = 1'b1;
        @(negedge clk);
        drain("rerun", 3, 16'hFFFF, 0, 0, 5);

`ifdef DRAIN_LAST_EN
        drain("last", 5, 16'hFFFF, 1, 0, -1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
